// File: rtl/mem_stage_if.sv
// EXE/MEM to MEM/WB bundle for the memory-access stage.
// The master side is the upstream pipeline register; the slave side is mem_stage.
interface mem_stage_if;
  logic        Branch_in;
  logic        MemWrite_in;
  logic        MemRead_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic        zero_in;
  logic [4:0]  Destination_in;
  logic [31:0] branchAdd_in;
  logic [31:0] ALUresult_in;
  logic [31:0] Rt_Data_in;

  logic        PCSrc;
  logic [31:0] branch_target;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic [4:0]  Destination_out;
  logic [31:0] ALUresult_out;
  logic [31:0] ReadData_out;
  logic        misalign_err;

  modport master (
    output Branch_in, MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in, zero_in,
           Destination_in, branchAdd_in, ALUresult_in, Rt_Data_in,
    input  PCSrc, branch_target, MemToReg_out, RegWrite_out, Destination_out,
           ALUresult_out, ReadData_out, misalign_err
  );

  modport slave (
    input  Branch_in, MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in, zero_in,
           Destination_in, branchAdd_in, ALUresult_in, Rt_Data_in,
    output PCSrc, branch_target, MemToReg_out, RegWrite_out, Destination_out,
           ALUresult_out, ReadData_out, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word data memory, branch resolution and the MEM/WB register.
// Loads and stores must be word aligned; a misaligned access is dropped and flagged.
module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_if.slave        bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Contents survive rst; only the power-up value is defined.
  logic [31:0] mem [0:DEPTH-1] = '{default: '0};

  logic [ADDR_W-1:0] index;
  logic              misaligned;
  logic              do_store;
  logic              do_load;

  assign index      = bus.ALUresult_in[ADDR_W+1:2];
  assign misaligned = (bus.MemRead_in | bus.MemWrite_in) & (bus.ALUresult_in[1:0] != 2'b00);
  assign do_store   = bus.MemWrite_in & ~misaligned;
  assign do_load    = bus.MemRead_in & ~misaligned;

  assign bus.PCSrc         = bus.Branch_in & bus.zero_in & ~rst;
  assign bus.branch_target = bus.branchAdd_in;
  assign dbg_data          = mem[dbg_addr];

  // A store coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && do_store) begin
      mem[index] <= bus.Rt_Data_in;
    end
  end

  // The load reads the pre-edge contents, giving read-before-write on a combined access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MemToReg_out    <= 1'b0;
      bus.RegWrite_out    <= 1'b0;
      bus.Destination_out <= 5'd0;
      bus.ALUresult_out   <= 32'd0;
      bus.ReadData_out    <= 32'd0;
      bus.misalign_err    <= 1'b0;
    end else begin
      bus.MemToReg_out    <= bus.MemToReg_in;
      bus.RegWrite_out    <= bus.RegWrite_in;
      bus.Destination_out <= bus.Destination_in;
      bus.ALUresult_out   <= bus.ALUresult_in;
      bus.ReadData_out    <= do_load ? mem[index] : 32'd0;
      bus.misalign_err    <= bus.misalign_err | misaligned;
    end
  end
endmodule
